// File: rtl/dff_chk_pkg.sv
// -----------------------------------------------------------------------------
// dff_chk_pkg
//   Shared types and default sizes for the DFF checker (dff_chk_monitor).
//   Contents:
//     chk_state_e    checker FSM state: IDLE, CHECK, FAIL
//     DEF_LATENCY    default d->q delay of the DUT in clock cycles
//     DEF_CNT_W      default width of the sample/error counters
//     DEF_MAX_ERR    default error count that forces FAIL (0 = never)
//   Optional feature macro used by the checker: DFF_CHK_MONITOR_FIRST_ERR_EN
// -----------------------------------------------------------------------------
package dff_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FAIL  = 2'd2
    } chk_state_e;

    localparam int DEF_LATENCY = 1;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_MAX_ERR = 8;

endpackage : dff_chk_pkg

// File: rtl/dff_chk_monitor_if.sv
// -----------------------------------------------------------------------------
// dff_chk_monitor_if
//   Bundles the checker's stimulus-side and result-side signals.
//   Parameter: CNT_W  width of smp_cnt / err_cnt (and first_err_idx)
//   Signals:
//     en             check enable
//     clear          synchronous clear of counters/state
//     d              DUT data input as driven
//     q              DUT data output as observed
//     mismatch       registered 1-cycle pulse after a failing compare
//     smp_cnt        saturating count of compares performed
//     err_cnt        saturating count of mismatches
//     fail           high while the checker sits in FAIL
//     first_err_vld  (DFF_CHK_MONITOR_FIRST_ERR_EN only) first error captured
//     first_err_idx  (DFF_CHK_MONITOR_FIRST_ERR_EN only) smp_cnt at first error
//   Modports:
//     master  harness side: drives en/clear/d/q, observes results
//     slave   checker side: samples en/clear/d/q, drives results
// -----------------------------------------------------------------------------
interface dff_chk_monitor_if
    import dff_chk_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             en;
    logic             clear;
    logic             d;
    logic             q;
    logic             mismatch;
    logic [CNT_W-1:0] smp_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             fail;
`ifdef DFF_CHK_MONITOR_FIRST_ERR_EN
    logic             first_err_vld;
    logic [CNT_W-1:0] first_err_idx;
`endif

    modport master (
        output en, clear, d, q,
        input  mismatch, smp_cnt, err_cnt, fail
`ifdef DFF_CHK_MONITOR_FIRST_ERR_EN
        , input first_err_vld, first_err_idx
`endif
    );

    modport slave (
        input  en, clear, d, q,
        output mismatch, smp_cnt, err_cnt, fail
`ifdef DFF_CHK_MONITOR_FIRST_ERR_EN
        , output first_err_vld, first_err_idx
`endif
    );

endinterface : dff_chk_monitor_if

// File: rtl/dff_chk_sat_cnt.sv
// -----------------------------------------------------------------------------
// dff_chk_sat_cnt
//   Saturating up-counter: holds at all-ones instead of wrapping.
//   Priority: rst > clr > inc.
//   Parameter: W  counter width
//   Ports:
//     clk  in   clock, posedge
//     rst  in   synchronous active-high reset (count -> 0)
//     clr  in   synchronous clear (count -> 0)
//     inc  in   increment request
//     cnt  out  current count [W-1:0]
// -----------------------------------------------------------------------------
module dff_chk_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : dff_chk_sat_cnt

// File: rtl/dff_chk_monitor.sv
// -----------------------------------------------------------------------------
// dff_chk_monitor
//   Passive hardware scoreboard for a DFF-style DUT. Keeps a LATENCY-deep
//   history of d, compares the delayed value against q while enabled, counts
//   compares and mismatches (both saturating) and latches a FAIL state once
//   MAX_ERR mismatches have been seen.
//   Parameters:
//     LATENCY  DUT d->q delay in cycles (>= 1)
//     CNT_W    counter width (must match the interface's CNT_W, <= 32)
//     MAX_ERR  mismatch count that forces FAIL; 0 disables FAIL
//   Ports:
//     clk  in   clock, all logic on posedge
//     rst  in   synchronous active-high reset (same reset the DUT sees)
//     bus  slave modport of dff_chk_monitor_if (en, clear, d, q in;
//          mismatch, smp_cnt, err_cnt, fail out)
//   Optional: define DFF_CHK_MONITOR_FIRST_ERR_EN to add first_err_vld /
//   first_err_idx, which capture the pre-increment smp_cnt of the first
//   mismatch after rst/clear.
// -----------------------------------------------------------------------------
module dff_chk_monitor
    import dff_chk_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MAX_ERR = DEF_MAX_ERR
) (
    input  logic               clk,
    input  logic               rst,
    dff_chk_monitor_if.slave   bus
);

    localparam logic [31:0] MAX_ERR_U = 32'(MAX_ERR);

    chk_state_e         state_q;
    logic               mismatch_q;
    logic [LATENCY-1:0] hist_q;
    logic [LATENCY-1:0] hist_d;
    logic [CNT_W-1:0]   smp_cnt;
    logic [CNT_W-1:0]   err_cnt;
    logic [CNT_W-1:0]   err_nxt;
    logic               exp_bit;
    logic               cmp;
    logic               miss;
    logic               err_inc;
    logic               hit_max;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // History shifts every cycle regardless of en/state/clear; oldest entry
    // is the value q should show now.
    always_comb begin
        hist_d    = hist_q;
        hist_d[0] = bus.d;
        for (int i = 1; i < LATENCY; i++) begin
            hist_d[i] = hist_q[i-1];
        end
    end

    assign exp_bit = hist_q[LATENCY-1];

    // clear takes precedence over a compare in the same cycle.
    assign cmp     = (state_q == CHECK) && bus.en && !bus.clear;
    // Case inequality so an X/Z on q is reported as a mismatch in simulation.
    assign miss    = (bus.q !== exp_bit);
    assign err_inc = cmp && miss;
    assign err_nxt = sat_inc(err_cnt);
    assign hit_max = (MAX_ERR_U != 32'd0) && (32'(err_nxt) == MAX_ERR_U);

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mismatch_q <= 1'b0;
        end else if (bus.clear) begin
            state_q    <= IDLE;
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= err_inc;
            case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (!bus.en) begin
                        state_q <= IDLE;
                    end else if (err_inc && hit_max) begin
                        state_q <= FAIL;
                    end
                end
                FAIL: begin
                    state_q <= FAIL;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Counters only advance on a compare, which never happens in FAIL, so
    // they freeze there without extra gating.
    dff_chk_sat_cnt #(.W(CNT_W)) u_smp_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear),
        .inc (cmp),
        .cnt (smp_cnt)
    );

    dff_chk_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear),
        .inc (err_inc),
        .cnt (err_cnt)
    );

    assign bus.mismatch = mismatch_q;
    assign bus.smp_cnt  = smp_cnt;
    assign bus.err_cnt  = err_cnt;
    assign bus.fail     = (state_q == FAIL);

`ifdef DFF_CHK_MONITOR_FIRST_ERR_EN
    logic             first_err_vld_q;
    logic [CNT_W-1:0] first_err_idx_q;

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            first_err_vld_q <= 1'b0;
            first_err_idx_q <= '0;
        end else if (err_inc && !first_err_vld_q) begin
            first_err_vld_q <= 1'b1;
            first_err_idx_q <= smp_cnt;
        end
    end

    assign bus.first_err_vld = first_err_vld_q;
    assign bus.first_err_idx = first_err_idx_q;
`endif

endmodule : dff_chk_monitor
